// File: rtl/dmem_posted_responder.sv
// rtl/dmem_posted_responder.sv - M-stage data memory with posted-write FIFO draining into a slow word RAM.
// Loads bypass the FIFO (youngest matching store wins); stores stall only when the FIFO is full.
module dmem_posted_responder #(
  parameter int DEPTH_WORDS  = 64,
  parameter int BUF_DEPTH    = 4,
  parameter int DRAIN_CYCLES = 3
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         we,
  input  logic [31:0]                  addr,
  input  logic [31:0]                  wdata,
  output logic [31:0]                  rdata,
  output logic                         stall,
  output logic                         pending,
  output logic [$clog2(BUF_DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int BW = $clog2(BUF_DEPTH);
  localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  typedef enum logic {IDLE, DRAIN} state_t;

  state_t            state;
  logic [BW-1:0]     wr_ptr;
  logic [BW-1:0]     rd_ptr;
  logic [DW-1:0]     drain_cnt;
  logic [BW:0]       count_next;
  logic [BW-1:0]     pos;

  logic [AW-1:0]     buf_idx  [BUF_DEPTH];
  logic [31:0]       buf_data [BUF_DEPTH];
  logic [31:0]       ram      [DEPTH_WORDS];

  logic [AW-1:0]     widx;
  logic              full;
  logic              push;
  logic              commit;
  logic              unused_addr_bits;

  assign widx             = addr[AW+1:2];
  assign unused_addr_bits = ^{addr[31:AW+2], addr[1:0]};

  // Full is decoded from the registered count, so a same-edge commit never admits a store.
  assign full   = (count == (BW+1)'(BUF_DEPTH));
  assign stall  = we & full;
  assign push   = we & ~full;
  assign commit = (state == DRAIN) && (drain_cnt == DW'(DRAIN_CYCLES - 1));

  always_comb begin
    count_next = count;
    case ({push, commit})
      2'b10:   count_next = count + 1'b1;
      2'b01:   count_next = count - 1'b1;
      default: count_next = count;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      drain_cnt <= '0;
      pending   <= 1'b0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (commit)
        rd_ptr <= rd_ptr + 1'b1;
      count   <= count_next;
      pending <= (count_next != '0);
      case (state)
        IDLE: begin
          drain_cnt <= '0;
          if (count_next != '0)
            state <= DRAIN;
        end
        DRAIN: begin
          if (commit)
            drain_cnt <= '0;
          else
            drain_cnt <= drain_cnt + 1'b1;
          if (count_next == '0)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Buffer and RAM arrays carry no reset; a reset simply forgets the buffered entries.
  always_ff @(posedge clk) begin
    if (push) begin
      buf_idx[wr_ptr]  <= widx;
      buf_data[wr_ptr] <= wdata;
    end
    if (commit)
      ram[buf_idx[rd_ptr]] <= buf_data[rd_ptr];
  end

  // Walk oldest to youngest so the last match left standing is the youngest store.
  always_comb begin
    rdata = ram[widx];
    pos   = '0;
    for (int i = 0; i < BUF_DEPTH; i++) begin
      pos = rd_ptr + BW'(i);
      if (((BW+1)'(i) < count) && (buf_idx[pos] == widx))
        rdata = buf_data[pos];
    end
  end

endmodule
